vanilla_dmem_arbiter: RTL and testbench

- Shares the tile's single-port data memory between two requesters: the vanilla core's local load/store path and the network receive path's remote DMEM requests.
- The core has default priority. A starvation counter forces a remote grant after a bounded wait.
- Read data returns one cycle after grant and is routed back to the requester that issued the read.
- Sits between vanilla_core / network_rx and the DMEM macro inside the processor tile.

---
 rtl/vanilla_dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_vanilla_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vanilla_dmem_arbiter.sv
// Two-way arbiter sharing the tile DMEM between the core and remote requests.
// Optional VANILLA_DMEM_ARB_PERF_EN adds conflict/force performance counters.
module vanilla_dmem_arbiter #(
  parameter int data_width_p   = 32,
  parameter int dmem_size_p    = 1024,
  parameter int starve_limit_p = 4,
  localparam int data_mask_width_lp  = data_width_p >> 3,
  localparam int dmem_addr_width_lp  = (dmem_size_p > 1) ? $clog2(dmem_size_p) : 1,
  localparam int starve_cnt_width_lp = (starve_limit_p + 1 > 1) ? $clog2(starve_limit_p + 1) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,

  input  logic                          core_v_i,
  input  logic                          core_w_i,
  input  logic [dmem_addr_width_lp-1:0] core_addr_i,
  input  logic [data_width_p-1:0]       core_data_i,
  input  logic [data_mask_width_lp-1:0] core_mask_i,
  output logic                          core_yumi_o,
  output logic                          core_data_v_o,
  output logic [data_width_p-1:0]       core_data_o,

  input  logic                          remote_v_i,
  input  logic                          remote_w_i,
  input  logic [dmem_addr_width_lp-1:0] remote_addr_i,
  input  logic [data_width_p-1:0]       remote_data_i,
  input  logic [data_mask_width_lp-1:0] remote_mask_i,
  output logic                          remote_yumi_o,
  output logic                          remote_data_v_o,
  output logic [data_width_p-1:0]       remote_data_o,

  output logic                          mem_v_o,
  output logic                          mem_w_o,
  output logic [dmem_addr_width_lp-1:0] mem_addr_o,
  output logic [data_width_p-1:0]       mem_data_o,
  output logic [data_mask_width_lp-1:0] mem_mask_o,
  input  logic [data_width_p-1:0]       mem_data_i
`ifdef VANILLA_DMEM_ARB_PERF_EN
  ,
  output logic [31:0]                   conflict_cnt_o,
  output logic [31:0]                   force_cnt_o
`endif
);

  // rd_owner_r | meaning
  // NONE       | no read in flight
  // CORE       | read data next cycle belongs to the core
  // REMOTE     | read data next cycle belongs to the remote path
  localparam logic [1:0] owner_none_lp   = 2'd0;
  localparam logic [1:0] owner_core_lp   = 2'd1;
  localparam logic [1:0] owner_remote_lp = 2'd2;

  localparam logic [starve_cnt_width_lp-1:0] starve_limit_lp =
    starve_cnt_width_lp'(starve_limit_p);

  logic [starve_cnt_width_lp-1:0] starve_cnt_r;
  logic [1:0]                     rd_owner_r;
  logic                           rd_pending_r;

  logic force_remote;
  logic remote_grant;
  logic core_grant;
  logic core_rd;
  logic remote_rd;

  assign force_remote = (starve_cnt_r == starve_limit_lp);
  // Reset gating keeps every handshake and the DMEM enable quiet while held.
  assign remote_grant = reset_n_i & remote_v_i & (~core_v_i | force_remote);
  assign core_grant   = reset_n_i & core_v_i & ~remote_grant;
  assign core_rd      = core_grant & ~core_w_i;
  assign remote_rd    = remote_grant & ~remote_w_i;

  assign core_yumi_o   = core_grant;
  assign remote_yumi_o = remote_grant;

  assign mem_v_o    = core_grant | remote_grant;
  assign mem_w_o    = remote_grant ? remote_w_i    : core_w_i;
  assign mem_addr_o = remote_grant ? remote_addr_i : core_addr_i;
  assign mem_data_o = remote_grant ? remote_data_i : core_data_i;
  assign mem_mask_o = remote_grant ? remote_mask_i : core_mask_i;

  assign core_data_v_o   = rd_pending_r & (rd_owner_r == owner_core_lp);
  assign remote_data_v_o = rd_pending_r & (rd_owner_r == owner_remote_lp);
  assign core_data_o     = mem_data_i;
  assign remote_data_o   = mem_data_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_cnt_r <= '0;
    end else if (remote_grant || !remote_v_i) begin
      starve_cnt_r <= '0;
    end else if (core_grant && (starve_cnt_r != starve_limit_lp)) begin
      starve_cnt_r <= starve_cnt_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_pending_r <= 1'b0;
      rd_owner_r   <= owner_none_lp;
    end else begin
      rd_pending_r <= core_rd | remote_rd;
      if (remote_rd)
        rd_owner_r <= owner_remote_lp;
      else if (core_rd)
        rd_owner_r <= owner_core_lp;
      else
        rd_owner_r <= owner_none_lp;
    end
  end

`ifdef VANILLA_DMEM_ARB_PERF_EN
  logic [31:0] conflict_cnt_r;
  logic [31:0] force_cnt_r;

  // A forced grant is one where the remote side won over a valid core request.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      conflict_cnt_r <= '0;
      force_cnt_r    <= '0;
    end else begin
      if (core_v_i && remote_v_i)
        conflict_cnt_r <= conflict_cnt_r + 32'd1;
      if (remote_grant && force_remote && core_v_i)
        force_cnt_r <= force_cnt_r + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_r;
  assign force_cnt_o    = force_cnt_r;
`endif

endmodule

// File: tb/tb_vanilla_dmem_arbiter.sv
// Self-checking bench for vanilla_dmem_arbiter: directed cases plus random traffic
// against a requester-level model with its own reference memory.
module tb_vanilla_dmem_arbiter;
  localparam int DW    = 32;
  localparam int SIZE  = 1024;
  localparam int LIMIT = 4;
  localparam int AW    = 10;
  localparam int MW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_v = 0, core_w = 0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_data = '0;
  logic [MW-1:0] core_mask = '0;
  logic          remote_v = 0, remote_w = 0;
  logic [AW-1:0] remote_addr = '0;
  logic [DW-1:0] remote_data = '0;
  logic [MW-1:0] remote_mask = '0;
  logic          core_yumi, core_data_v, remote_yumi, remote_data_v;
  logic [DW-1:0] core_rdata, remote_rdata;
  logic          mem_v, mem_w;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_mask;
  logic [DW-1:0] mem_rdata = '0;
`ifdef VANILLA_DMEM_ARB_PERF_EN
  logic [31:0]   conflict_cnt, force_cnt;
`endif

  always #5 clk = ~clk;

  vanilla_dmem_arbiter #(.data_width_p(DW), .dmem_size_p(SIZE), .starve_limit_p(LIMIT)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .core_v_i(core_v), .core_w_i(core_w), .core_addr_i(core_addr),
    .core_data_i(core_data), .core_mask_i(core_mask),
    .core_yumi_o(core_yumi), .core_data_v_o(core_data_v), .core_data_o(core_rdata),
    .remote_v_i(remote_v), .remote_w_i(remote_w), .remote_addr_i(remote_addr),
    .remote_data_i(remote_data), .remote_mask_i(remote_mask),
    .remote_yumi_o(remote_yumi), .remote_data_v_o(remote_data_v), .remote_data_o(remote_rdata),
    .mem_v_o(mem_v), .mem_w_o(mem_w), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_mask_o(mem_mask), .mem_data_i(mem_rdata)
`ifdef VANILLA_DMEM_ARB_PERF_EN
    , .conflict_cnt_o(conflict_cnt), .force_cnt_o(force_cnt)
`endif
  );

  // DMEM macro stand-in; drives junk when no read was issued
  logic [DW-1:0] dmem [SIZE];
  always @(posedge clk) begin
    if (mem_v && mem_w) begin
      for (int b = 0; b < MW; b++)
        if (mem_mask[b]) dmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= (mem_v && !mem_w) ? dmem[mem_addr] : $urandom;
  end

  // reference model state
  logic [DW-1:0] ref_mem [SIZE];
  int            wait_cnt;
  bit            pend_v;
  bit            pend_remote;
  logic [DW-1:0] pend_data;

  int checks = 0;
  int errors = 0;

  // DUT values sampled at the last negedge
  logic          s_cy, s_ry, s_cdv, s_rdv, s_mw;
  logic [DW-1:0] s_cd, s_rd;
  logic [MW-1:0] s_mmask;
  logic [AW-1:0] s_maddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r = old;
    for (int b = 0; b < MW; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // one clock: compare at negedge, advance model, return at posedge+1
  task automatic step();
    bit exp_rg, exp_cg;
    @(negedge clk);
    exp_rg = remote_v && (!core_v || wait_cnt >= LIMIT);
    exp_cg = core_v && !exp_rg;
    s_cy = core_yumi; s_ry = remote_yumi; s_cdv = core_data_v; s_rdv = remote_data_v;
    s_cd = core_rdata; s_rd = remote_rdata; s_mw = mem_w; s_mmask = mem_mask; s_maddr = mem_addr;
    chk("core_yumi", 32'(core_yumi), 32'(exp_cg));
    chk("remote_yumi", 32'(remote_yumi), 32'(exp_rg));
    chk("mem_v", 32'(mem_v), 32'(exp_cg | exp_rg));
    if (exp_cg || exp_rg) begin
      chk("mem_w", 32'(mem_w), 32'(exp_rg ? remote_w : core_w));
      chk("mem_addr", 32'(mem_addr), 32'(exp_rg ? remote_addr : core_addr));
      if (mem_w) begin
        chk("mem_data", mem_wdata, exp_rg ? remote_data : core_data);
        chk("mem_mask", 32'(mem_mask), 32'(exp_rg ? remote_mask : core_mask));
      end
    end
    chk("core_data_v", 32'(core_data_v), 32'(pend_v && !pend_remote));
    chk("remote_data_v", 32'(remote_data_v), 32'(pend_v && pend_remote));
    if (pend_v && !pend_remote) chk("core_data", core_rdata, pend_data);
    if (pend_v && pend_remote)  chk("remote_data", remote_rdata, pend_data);
    pend_v = 0;
    if (exp_rg) begin
      if (remote_w) ref_mem[remote_addr] = merge(ref_mem[remote_addr], remote_data, remote_mask);
      else begin pend_v = 1; pend_remote = 1; pend_data = ref_mem[remote_addr]; end
    end else if (exp_cg) begin
      if (core_w) ref_mem[core_addr] = merge(ref_mem[core_addr], core_data, core_mask);
      else begin pend_v = 1; pend_remote = 0; pend_data = ref_mem[core_addr]; end
    end
    if (exp_rg || !remote_v) wait_cnt = 0;
    else if (exp_cg) wait_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_core_yumi", 32'(core_yumi), 0);
    chk("rst_remote_yumi", 32'(remote_yumi), 0);
    chk("rst_mem_v", 32'(mem_v), 0);
    chk("rst_data_v", 32'({core_data_v, remote_data_v}), 0);
    wait_cnt = 0; pend_v = 0;
    @(negedge clk);
    chk("rst_mem_v_hold", 32'(mem_v), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic new_core(input bit w);
    core_w = w; core_addr = AW'($urandom_range(0, 31)); core_data = $urandom; core_mask = MW'($urandom);
  endtask
  task automatic new_remote(input bit w);
    remote_w = w; remote_addr = AW'($urandom_range(0, 31)); remote_data = $urandom; remote_mask = MW'($urandom);
  endtask

  // continuous contention of reads; bits[i] set when remote was granted in cycle i
  task automatic contend(input int n, output logic [31:0] bits);
    bits = '0;
    core_v = 1; remote_v = 1;
    for (int i = 0; i < n; i++) begin
      step();
      bits[i] = s_ry;
      if (s_cy) new_core(0);
      if (s_ry) new_remote(0);
    end
  endtask

  initial begin
    logic [31:0] bits;
    for (int i = 0; i < SIZE; i++) begin
      dmem[i] = $urandom; ref_mem[i] = dmem[i];
    end
    dmem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    dmem[7]  = 32'h12345678; ref_mem[7]  = 32'h12345678;
    wait_cnt = 0; pend_v = 0; pend_remote = 0; pend_data = '0;

    core_v = 1; remote_v = 1;
    do_reset();
    core_v = 0; remote_v = 0;
    step();

    // core read of 0x10
    core_v = 1; core_w = 0; core_addr = 10'h10;
    step();
    chk("cr_yumi", 32'(s_cy), 1);
    core_v = 0;
    step();
    chk("cr_data_v", 32'(s_cdv), 1);
    chk("cr_data", s_cd, 32'hDEADBEEF);
    chk("cr_remote_v", 32'(s_rdv), 0);

    // contention pattern with period LIMIT+1
    new_core(0); new_remote(0);
    contend(15, bits);
    chk("contend_pattern", bits, 32'h0000_4210);
    core_v = 0; remote_v = 0;
    step();

    // remote masked write then read of addr 7
    remote_v = 1; remote_w = 1; remote_addr = 7; remote_data = 32'hA5A5A5A5; remote_mask = 4'b0011;
    step();
    chk("rw_yumi", 32'(s_ry), 1);
    chk("rw_mem_w", 32'(s_mw), 1);
    chk("rw_mask", 32'(s_mmask), 32'h3);
    chk("rw_addr", 32'(s_maddr), 7);
    remote_w = 0;
    step();
    remote_v = 0;
    step();
    chk("rr_data_v", 32'(s_rdv), 1);
    chk("rr_data", s_rd, 32'h1234A5A5);
    chk("rr_core_v", 32'(s_cdv), 0);

    // back-to-back reads alternating owners
    core_v = 1; core_w = 0; core_addr = 1;
    step();
    core_v = 0; remote_v = 1; remote_w = 0; remote_addr = 2;
    step();
    chk("b2b_1_core", 32'({s_cdv, s_rdv}), 32'b10);
    remote_v = 0; core_v = 1; core_addr = 3;
    step();
    chk("b2b_2_remote", 32'({s_cdv, s_rdv}), 32'b01);
    core_v = 0;
    step();
    chk("b2b_3_core", 32'({s_cdv, s_rdv}), 32'b10);

    // reset right after a core read grant with a partly charged counter
    new_core(0); new_remote(0);
    contend(3, bits);
    chk("pre_rst_pattern", bits, 0);
    do_reset();
    new_core(0); new_remote(0);
    contend(6, bits);
    chk("post_rst_pattern", bits, 32'h10);
    core_v = 0; remote_v = 0;
    step();

`ifdef VANILLA_DMEM_ARB_PERF_EN
    new_core(0); new_remote(0);
    core_v = 1; remote_v = 1;
    do_reset();
    contend(10, bits);
    chk("perf_conflict", conflict_cnt, 10);
    chk("perf_force", force_cnt, 2);
    core_v = 0; remote_v = 0;
    step();
`endif

    // random traffic with valid/yumi handshakes
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!core_v || s_cy) begin
        core_v = ($urandom_range(0, 3) != 0);
        new_core(1'($urandom));
      end
      if (!remote_v || s_ry) begin
        remote_v = ($urandom_range(0, 2) != 0);
        new_remote(1'($urandom));
      end
    end
    core_v = 0; remote_v = 0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
